// File: rtl/workboy_host.sv
// WorkBoy keyboard/RTC host: bit-banged serial master with key-poll and
// RTC-read operations, plus a 21-byte decoded RTC buffer.
module workboy_host #(
  parameter int CLK_HALF = 16,
  parameter int GAP      = 64
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       start,
  input  logic       op,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] key,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       serial_clk_out,
  output logic       serial_data_out,
  input  logic       serial_data_in
);

  localparam int              PH_MAX    = (CLK_HALF > GAP) ? CLK_HALF : GAP;
  localparam int              PH_W      = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0] CH_LAST   = PH_W'(CLK_HALF - 1);
  localparam logic [PH_W-1:0] GAP_LAST  = PH_W'(GAP - 1);
  localparam logic [PH_W-1:0] PH_ONE    = PH_W'(1);
  localparam logic [7:0]      TX_KEY    = 8'h4F;
  localparam logic [7:0]      TX_RTC    = 8'h52;
  localparam logic [7:0]      RX_ACK    = 8'h44;
  localparam int              BUF_DEPTH = 21;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_GAP,
    S_FINISH
  } state_t;

  state_t            r_state;
  logic [PH_W-1:0]   r_phase;
  logic [2:0]        r_bit;
  logic [5:0]        r_xfer;
  logic [7:0]        r_tx;
  logic [7:0]        r_rx;
  logic              r_op;
  logic              r_arm;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [7:0]        r_key;
  logic              r_sclk;
  logic              r_sdo;
  logic [7:0]        r_buf [BUF_DEPTH];

  logic [7:0]        w_rx_next;
  logic [4:0]        w_hex;
  logic [5:0]        w_k;
  logic [4:0]        w_buf_idx;
  logic              w_last;

  // Returns {valid, nibble}; invalid characters decode to nibble 0.
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39)
      return {1'b1, c[3:0]};
    else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
      return {1'b1, c[3:0] + 4'd9};
    else
      return 5'b0_0000;
  endfunction

  assign w_rx_next = {r_rx[6:0], serial_data_in};
  assign w_hex     = hex_decode(w_rx_next);
  assign w_k       = r_xfer - 6'd2;
  assign w_buf_idx = w_k[5:1];
  assign w_last    = r_op ? (r_xfer == 6'd43) : (r_xfer == 6'd1);

  assign busy            = r_busy;
  assign done            = r_done;
  assign err             = r_err;
  assign key             = r_key;
  assign serial_clk_out  = r_sclk;
  assign serial_data_out = r_sdo;
  // NOTE: a full conditional with an explicit else value keeps this read port purely combinational.
  assign rd_data = (rd_addr <= 5'd20) ? r_buf[rd_addr] : 8'h00;

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_phase <= '0;
      r_bit   <= '0;
      r_xfer  <= '0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_op    <= 1'b0;
      r_arm   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_key   <= 8'hFF;
      r_sclk  <= 1'b1;
      r_sdo   <= 1'b1;
      // NOTE: the buffer is architecturally visible after reset, so it is cleared here rather than left unreset like a RAM.
      for (int i = 0; i < BUF_DEPTH; i++) r_buf[i] <= 8'h00;
    end else begin
      r_arm  <= 1'b1;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && r_arm) begin
            r_op    <= op;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_LOW;
            r_phase <= '0;
            r_bit   <= '0;
            r_xfer  <= '0;
            r_tx    <= op ? TX_RTC : TX_KEY;
            r_sclk  <= 1'b0;
            r_sdo   <= op ? TX_RTC[7] : TX_KEY[7];
          end
        end

        S_LOW: begin
          if (r_phase == CH_LAST) begin
            r_phase <= '0;
            r_state <= S_HIGH;
            r_sclk  <= 1'b1;
            r_rx    <= w_rx_next;
            r_tx    <= {r_tx[6:0], 1'b0};
            // Byte is complete on the 8th rising edge; act on it right away.
            if (r_bit == 3'd7) begin
              if (!r_op) begin
                if (r_xfer == 6'd1) r_key <= w_rx_next;
              end else if (r_xfer == 6'd1) begin
                if (w_rx_next != RX_ACK) r_err <= 1'b1;
              end else if (r_xfer >= 6'd2) begin
                if (!w_hex[4]) r_err <= 1'b1;
                if (!w_k[0]) r_buf[w_buf_idx][7:4] <= w_hex[3:0];
                else         r_buf[w_buf_idx][3:0] <= w_hex[3:0];
              end
            end
          end else begin
            r_phase <= r_phase + PH_ONE;
          end
        end

        S_HIGH: begin
          if (r_phase == CH_LAST) begin
            r_phase <= '0;
            r_bit   <= r_bit + 3'd1;
            if (r_bit != 3'd7) begin
              r_state <= S_LOW;
              r_sclk  <= 1'b0;
              r_sdo   <= r_tx[7];
            end else begin
              r_sdo <= 1'b1;
              if (w_last) begin
                r_state <= S_FINISH;
              end else begin
                r_state <= S_GAP;
                r_xfer  <= r_xfer + 6'd1;
                r_tx    <= 8'h00;
              end
            end
          end else begin
            r_phase <= r_phase + PH_ONE;
          end
        end

        S_GAP: begin
          if (r_phase == GAP_LAST) begin
            r_phase <= '0;
            r_state <= S_LOW;
            r_sclk  <= 1'b0;
            r_sdo   <= r_tx[7];
          end else begin
            r_phase <= r_phase + PH_ONE;
          end
        end

        S_FINISH: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_phase <= '0;
          r_bit   <= '0;
          r_xfer  <= '0;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
